gpio_bus_arbiter: RTL and testbench
===================================

GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 Clock and reset SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 mN_read, mN_write (N=0,1)  input  1 each  Avalon-MM requester strobes; N=0 is the HPS bridge, N=1 is the hardware sequencer.
REQ-005 mN_address  input  3  register word index (0..7) of the GPIO slave.
REQ-006 mN_byteenable  input  4  byte lanes for the request.
REQ-007 mN_writedata  input  32  write data.
REQ-008 mN_readdata  output  32  read data, registered.
REQ-009 mN_waitrequest  output  1  stall to requester N.
REQ-010 s_chipselect, s_read, s_write  output  1 each  registered strobes to the GPIO slave.
REQ-011 s_address  output  3  registered.
REQ-012 s_byteenable  output  4  registered.
REQ-013 s_writedata  output  32  registered.
REQ-014 s_readdata  input  32  GPIO readdata, combinationally valid while s_chipselect and s_read are high.
REQ-015 mN_lock  input  1 each  hold-grant request; present only with GPIO_ARB_LOCK_EN.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, DONE and a 1-bit owner register.
REQ-017 In IDLE with any mN_read|mN_write high, the next state SHALL be ACCESS, with owner selected per REQ-018..020.
REQ-018 One requester active: that requester SHALL be granted.
REQ-019 Both active: the requester other than last_owner SHALL be granted (round robin).
REQ-020 mN_read and mN_write both high on the same requester: write SHALL win, and read SHALL be ignored.
REQ-021 On entry to ACCESS, the arbiter SHALL latch the owner's address, byteenable, writedata and direction into the s_* registers.
REQ-022 In ACCESS, s_chipselect and s_read/s_write SHALL be high for exactly one cycle; write strobes are never wider than one cycle, as required for the write-1-clear status register at address 7.
REQ-023 The end of ACCESS SHALL capture s_readdata into the owner's mN_readdata when reading; writes SHALL leave mN_readdata unchanged.
REQ-024 ACCESS SHALL always go to DONE; DONE SHALL update last_owner to the owner and go to IDLE.
REQ-025 mN_waitrequest SHALL equal (mN_read|mN_write) AND NOT (state==DONE AND owner==N), combinationally.
REQ-026 Latency SHALL be three cycles from request sampled in IDLE to waitrequest low; back-to-back throughput SHALL be one transfer per 3 cycles.
REQ-027 A request dropped by the master before DONE SHALL still complete its slave access; the arbiter never aborts an issued strobe.
REQ-028 s_* strobes SHALL be low in IDLE and DONE.
REQ-029 Non-strobe s_* values SHALL hold their last value.

Reset
REQ-030 Reset SHALL force state=IDLE, owner=0 and last_owner=1, so requester 0 wins the first tie.
REQ-031 Reset SHALL clear all s_* outputs and mN_readdata to 0.
REQ-032 Reset mid-transfer SHALL drop the transfer.
REQ-033 mN_waitrequest SHALL follow REQ-025 during reset, high if a request is pending, so masters re-issue after reset.

Configuration
REQ-034 With GPIO_ARB_LOCK_EN defined, the mN_lock ports SHALL exist.
REQ-035 With GPIO_ARB_LOCK_EN, if owner's mN_lock is high in DONE, a locked flag SHALL be set, and the next IDLE arbitration SHALL grant only that owner, ignoring the other requester.
REQ-036 With GPIO_ARB_LOCK_EN, the locked flag SHALL clear in any DONE where the owner's lock is low.
REQ-037 With GPIO_ARB_LOCK_EN, reset SHALL clear the locked flag.
REQ-038 Without GPIO_ARB_LOCK_EN, the mN_lock ports SHALL be absent, and arbitration SHALL be pure round robin per REQ-018..019.

Verification
REQ-039 Single read: m0 reads address 0 with s_readdata=0xA5A5_0001 -> s_read high exactly 1 cycle with s_address=0; m0_waitrequest low on cycle 3; m0_readdata=0xA5A5_0001.
REQ-040 Tie after reset: m0 and m1 write together (0x11, 0x22 to address 1) -> m0 is served first; m1 is served next with s_writedata=0x22; the next tie grants m0 again.
REQ-041 W1C: m1 writes 0xFFFF_FFFF to address 7 -> s_write high exactly 1 cycle; no second write occurs while m1 holds the request until waitrequest falls.
REQ-042 Reset in ACCESS: assert reset while s_write is high -> all s_* go to 0 asynchronously; after release, the pending m0 request re-arbitrates, with m0 winning any tie.
REQ-043 Lock (macro on): m0 performs a read of address 1 then a write, with m0_lock=1 on the first, while m1 requests throughout -> m1 is not granted until the m0 write's DONE cycle has passed with m0_lock=0.
REQ-044 Lock (macro off): same stimulus as REQ-043 -> accesses are granted alternating m0, m1, m0.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter
// Description : Two-requester Avalon-MM arbiter (HPS bridge, HW sequencer)
//               onto a single GPIO slave. Round-robin grant, one-cycle slave
//               strobes. Optional hold-grant lock via `GPIO_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [2:0]  m0_address,
    input  logic [3:0]  m0_byteenable,
    input  logic [31:0] m0_writedata,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
`ifdef GPIO_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [2:0]  m1_address,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic        s_chipselect,
    output logic        s_read,
    output logic        s_write,
    output logic [2:0]  s_address,
    output logic [3:0]  s_byteenable,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_owner;
    logic        r_last_owner;
    logic        w_grant;
    logic [1:0]  w_req;
    logic [1:0]  w_cand;
    logic        w_start;
    logic        w_sel_read;
    logic        w_sel_write;
    logic [2:0]  w_sel_address;
    logic [3:0]  w_sel_byteenable;
    logic [31:0] w_sel_writedata;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

`ifdef GPIO_ARB_LOCK_EN
    logic r_locked;
    logic w_owner_lock;
    assign w_owner_lock = r_owner ? m1_lock : m0_lock;
`endif

    // Fields of the requester about to be granted
    assign w_sel_read       = w_grant ? m1_read       : m0_read;
    assign w_sel_write      = w_grant ? m1_write      : m0_write;
    assign w_sel_address    = w_grant ? m1_address    : m0_address;
    assign w_sel_byteenable = w_grant ? m1_byteenable : m0_byteenable;
    assign w_sel_writedata  = w_grant ? m1_writedata  : m0_writedata;
    assign w_start          = (r_state == c_IDLE) && (w_next_state == c_ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = r_owner;
        w_cand       = w_req;
`ifdef GPIO_ARB_LOCK_EN
        // A held grant hides the other requester entirely
        if (r_locked)
            w_cand = w_req & (r_owner ? 2'b10 : 2'b01);
`endif
        case (r_state)
            c_IDLE: begin
                if (w_cand != 2'b00) begin
                    w_next_state = c_ACCESS;
                    case (w_cand)
                        2'b01:   w_grant = 1'b0;
                        2'b10:   w_grant = 1'b1;
                        default: w_grant = ~r_last_owner;
                    endcase
                end
            end
            c_ACCESS: w_next_state = c_DONE;
            c_DONE:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        m0_waitrequest = w_req[0] & ~((r_state == c_DONE) && (r_owner == 1'b0));
        m1_waitrequest = w_req[1] & ~((r_state == c_DONE) && (r_owner == 1'b1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            s_chipselect <= 1'b0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            s_address    <= 3'd0;
            s_byteenable <= 4'd0;
            s_writedata  <= 32'd0;
            m0_readdata  <= 32'd0;
            m1_readdata  <= 32'd0;
`ifdef GPIO_ARB_LOCK_EN
            r_locked     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: cleared unless a new access starts
            s_chipselect <= 1'b0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            if (w_start) begin
                r_owner      <= w_grant;
                s_chipselect <= 1'b1;
                s_write      <= w_sel_write;
                s_read       <= w_sel_read & ~w_sel_write;
                s_address    <= w_sel_address;
                s_byteenable <= w_sel_byteenable;
                s_writedata  <= w_sel_writedata;
            end
            if ((r_state == c_ACCESS) && s_read) begin
                if (r_owner)
                    m1_readdata <= s_readdata;
                else
                    m0_readdata <= s_readdata;
            end
            if (r_state == c_DONE) begin
                r_last_owner <= r_owner;
`ifdef GPIO_ARB_LOCK_EN
                r_locked     <= w_owner_lock;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gpio_bus_arbiter
// Description : Directed bench with a transaction-level arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_arbiter;

`ifdef GPIO_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_rd [2];
    logic        m_wr [2];
    logic        m_lk [2];
    logic [2:0]  m_addr [2];
    logic [3:0]  m_be [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_rdata [2];
    logic        m_wait [2];
    logic        s_cs, s_rd, s_wr;
    logic [2:0]  s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_rdata, rd_base;

    int errors = 0;
    int checks = 0;
    int nrd = 0;
    int nwr = 0;
    logic [2:0]  addr_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    // Slave returns an address-dependent pattern only while read-selected
    assign s_rdata = (s_cs && s_rd) ? rd_base + {29'd0, s_addr} : 32'hDEAD_BEEF;

    gpio_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_address(m_addr[0]),
        .m0_byteenable(m_be[0]), .m0_writedata(m_wd[0]),
        .m0_readdata(m_rdata[0]), .m0_waitrequest(m_wait[0]),
`ifdef GPIO_ARB_LOCK_EN
        .m0_lock(m_lk[0]), .m1_lock(m_lk[1]),
`endif
        .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_address(m_addr[1]),
        .m1_byteenable(m_be[1]), .m1_writedata(m_wd[1]),
        .m1_readdata(m_rdata[1]), .m1_waitrequest(m_wait[1]),
        .s_chipselect(s_cs), .s_read(s_rd), .s_write(s_wr),
        .s_address(s_addr), .s_byteenable(s_be), .s_writedata(s_wd),
        .s_readdata(s_rdata)
    );

    // Transaction model: a transfer occupies a 3-cycle slot (arbitrate,
    // strobe, complete); ph counts the remaining slot cycles.
    int          ph;
    bit          own, last, lkd;
    bit          mr0, mr1, g_any, g;
    logic        e_cs, e_rd, e_wr;
    logic [2:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rdata [2];

    always_comb begin
        mr0 = m_rd[0] | m_wr[0];
        mr1 = m_rd[1] | m_wr[1];
        if (LOCK_ON && lkd) begin
            if (own) mr0 = 1'b0;
            else     mr1 = 1'b0;
        end
        g_any = mr0 | mr1;
        g     = (mr0 && mr1) ? ~last : mr1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= 0; own <= 1'b0; last <= 1'b1; lkd <= 1'b0;
            e_cs <= 1'b0; e_rd <= 1'b0; e_wr <= 1'b0;
            e_addr <= 3'd0; e_be <= 4'd0; e_wd <= 32'd0;
            e_rdata[0] <= 32'd0; e_rdata[1] <= 32'd0;
        end else if (ph == 0) begin
            if (g_any) begin
                own <= g; ph <= 2; e_cs <= 1'b1;
                e_wr <= m_wr[g];
                e_rd <= m_rd[g] && !m_wr[g];
                e_addr <= m_addr[g]; e_be <= m_be[g]; e_wd <= m_wd[g];
            end
        end else if (ph == 2) begin
            if (e_rd) e_rdata[own] <= rd_base + {29'd0, e_addr};
            e_cs <= 1'b0; e_rd <= 1'b0; e_wr <= 1'b0;
            ph <= 1;
        end else begin
            last <= own;
            lkd  <= m_lk[own];
            ph   <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            chk("s_chipselect", 32'(s_cs), 32'(e_cs));
            chk("s_read", 32'(s_rd), 32'(e_rd));
            chk("s_write", 32'(s_wr), 32'(e_wr));
            chk("s_address", 32'(s_addr), 32'(e_addr));
            chk("s_byteenable", 32'(s_be), 32'(e_be));
            chk("s_writedata", s_wd, e_wd);
            chk("m0_readdata", m_rdata[0], e_rdata[0]);
            chk("m1_readdata", m_rdata[1], e_rdata[1]);
            chk("m0_waitrequest", 32'(m_wait[0]),
                32'((m_rd[0] | m_wr[0]) && !(ph == 1 && own == 1'b0)));
            chk("m1_waitrequest", 32'(m_wait[1]),
                32'((m_rd[1] | m_wr[1]) && !(ph == 1 && own == 1'b1)));
            if (s_cs) begin
                addr_q.push_back(s_addr);
                wd_q.push_back(s_wd);
                if (s_wr) nwr++;
                if (s_rd) nrd++;
            end
        end
    end

    // Waits for waitrequest low, then holds the request through the
    // completing edge before optionally dropping it.
    task automatic wait_done(input int n, input bit drop, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!m_wait[n]) done = 1'b1;
        end
        chk("wait_timeout", 32'(done), 32'd1);
        @(posedge clk); #2;
        if (drop) begin
            m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_lk[n] = 1'b0;
        end
    endtask

    task automatic xfer(input int n, input bit rd, input bit wr, input logic [2:0] a,
                        input logic [3:0] be, input logic [31:0] d, input bit lk,
                        input bit drop, output int cyc);
        m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = a;
        m_be[n] = be; m_wd[n] = d; m_lk[n] = lk;
        wait_done(n, drop, cyc);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
    endtask

    int c0, c0b, c1, base;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_lk[i] = 1'b0;
            m_addr[i] = 3'd0; m_be[i] = 4'd0; m_wd[i] = 32'd0;
        end
        rd_base = 32'hA5A5_0001;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_s_chipselect", 32'(s_cs), 32'd0);
        chk("rst_m0_readdata", m_rdata[0], 32'd0);
        chk("rst_m0_wait_idle", 32'(m_wait[0]), 32'd0);

        // Single read by m0 at address 0
        base = nrd;
        xfer(0, 1'b1, 1'b0, 3'd0, 4'hF, 32'd0, 1'b0, 1'b1, c0);
        chk("rd_latency", 32'(c0), 32'd3);
        chk("rd_data", m_rdata[0], 32'hA5A5_0001);
        chk("rd_strobe_cycles", 32'(nrd - base), 32'd1);
        chk("rd_address", 32'(addr_q[$]), 32'd0);

        // m1 read, read+write together (write wins)
        xfer(1, 1'b1, 1'b0, 3'd5, 4'h3, 32'd0, 1'b0, 1'b1, c1);
        chk("m1_rd_data", m_rdata[1], 32'hA5A5_0006);
        base = nwr;
        xfer(1, 1'b1, 1'b1, 3'd6, 4'hC, 32'h0BAD_F00D, 1'b0, 1'b1, c1);
        chk("rw_write_wins", 32'(nwr - base), 32'd1);
        chk("rw_keeps_rdata", m_rdata[1], 32'hA5A5_0006);

        // Tie after reset: m0, m1, then m0 again
        do_reset();
        wd_q.delete();
        fork
            xfer(0, 1'b0, 1'b1, 3'd1, 4'hF, 32'h11, 1'b0, 1'b1, c0);
            xfer(1, 1'b0, 1'b1, 3'd1, 4'hF, 32'h22, 1'b0, 1'b1, c1);
        join
        fork
            xfer(0, 1'b0, 1'b1, 3'd1, 4'hF, 32'h33, 1'b0, 1'b1, c0);
            xfer(1, 1'b0, 1'b1, 3'd1, 4'hF, 32'h44, 1'b0, 1'b1, c1);
        join
        chk("tie_count", 32'(wd_q.size()), 32'd4);
        chk("tie_first", wd_q[0], 32'h11);
        chk("tie_second", wd_q[1], 32'h22);
        chk("tie_third", wd_q[2], 32'h33);

        // W1C register write: exactly one write strobe
        base = nwr;
        xfer(1, 1'b0, 1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, c1);
        chk("w1c_strobes", 32'(nwr - base), 32'd1);
        chk("w1c_address", 32'(addr_q[$]), 32'd7);
        chk("w1c_keeps_rdata", m_rdata[1], 32'd0);

        // Reset while the write strobe is high
        do_reset();
        @(posedge clk); #2;
        m_wr[0] = 1'b1; m_addr[0] = 3'd4; m_be[0] = 4'hF; m_wd[0] = 32'h44;
        m_wr[1] = 1'b1; m_addr[1] = 3'd5; m_be[1] = 4'hF; m_wd[1] = 32'h55;
        @(posedge clk); #3;
        chk("pre_rst_s_write", 32'(s_wr), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_s_chipselect", 32'(s_cs), 32'd0);
        chk("async_s_write", 32'(s_wr), 32'd0);
        chk("async_s_address", 32'(s_addr), 32'd0);
        chk("async_s_writedata", s_wd, 32'd0);
        chk("rst_m0_wait_pending", 32'(m_wait[0]), 32'd1);
        chk("rst_m1_wait_pending", 32'(m_wait[1]), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        addr_q.delete();
        fork
            wait_done(0, 1'b1, c0);
            wait_done(1, 1'b1, c1);
        join
        chk("rearb_count", 32'(addr_q.size()), 32'd2);
        chk("rearb_first", 32'(addr_q[0]), 32'd4);
        chk("rearb_second", 32'(addr_q[1]), 32'd5);
        chk("rearb_latency", 32'(c0), 32'd3);

        // Locked read then write by m0 while m1 requests throughout
        do_reset();
        addr_q.delete();
        @(posedge clk); #2;
        fork
            begin
                xfer(0, 1'b1, 1'b0, 3'd1, 4'hF, 32'd0, 1'b1, 1'b0, c0);
                xfer(0, 1'b0, 1'b1, 3'd3, 4'hF, 32'h3333, 1'b0, 1'b1, c0b);
            end
            xfer(1, 1'b0, 1'b1, 3'd2, 4'hF, 32'hBBBB, 1'b0, 1'b1, c1);
        join
        chk("lock_count", 32'(addr_q.size()), 32'd3);
        chk("lock_first", 32'(addr_q[0]), 32'd1);
        chk("lock_second", 32'(addr_q[1]), LOCK_ON ? 32'd3 : 32'd2);
        chk("lock_third", 32'(addr_q[2]), LOCK_ON ? 32'd2 : 32'd3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
